// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: functional-unit indices,
// default widths and the per-FU result slot record.
package wb_pkg;

  localparam int NUM_FU_DEF = 5;
  localparam int DW_DEF     = 32;
  localparam int AW_DEF     = 5;

  localparam int FU_ALU  = 0;
  localparam int FU_MEM  = 1;
  localparam int FU_MUL  = 2;
  localparam int FU_DIV  = 3;
  localparam int FU_JUMP = 4;

  typedef struct packed {
    logic              full;
    logic [AW_DEF-1:0] rd;
    logic [DW_DEF-1:0] data;
  } slot_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin priority picker: grants the first requester found searching
// upward from ptr_i, wrapping around N.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers one result per functional unit and retires one
// register-file write per cycle in round-robin order.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_FU-1:0]  res_valid,
  input  logic [NUM_FU*AW-1:0] res_rd,
  input  logic [NUM_FU*DW-1:0] res_data,
  output logic [NUM_FU-1:0]  res_ready,
  input  logic               wb_stall,
  output logic               wb_we,
  output logic [AW-1:0]      wb_rd,
  output logic [DW-1:0]      wb_data,
  output logic [NUM_FU-1:0]  wb_fu,
  output logic [NUM_FU-1:0]  fu_release,
  output logic [2:0]         pend_cnt
);

  localparam int PW = $clog2(NUM_FU);

  slot_t             slot_q [NUM_FU];
  slot_t             slot_d [NUM_FU];
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] gnt;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              wb_we_q, wb_we_d;
  logic [AW-1:0]     wb_rd_q, wb_rd_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;
  logic [NUM_FU-1:0] wb_fu_q, wb_fu_d;
  logic [NUM_FU-1:0] rel_q, rel_d;
  logic [2:0]        pend_q, pend_d;

  always_comb begin
    full = '0;
    for (int i = 0; i < NUM_FU; i++) full[i] = slot_q[i].full;
  end

  // A stalled write port grants nothing, which also blocks same-cycle refill.
  assign req       = wb_stall ? '0 : full;
  assign gnt_any   = |gnt;
  assign res_ready = ~full | gnt;

  rr_pick #(.N(NUM_FU), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Drain first, then load, so a same-edge refill keeps the slot full.
  always_comb begin
    slot_d = slot_q;
    pend_d = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) slot_d[i].full = 1'b0;
      if (res_valid[i] && res_ready[i]) begin
        slot_d[i].full = 1'b1;
        slot_d[i].rd   = res_rd[i*AW +: AW];
        slot_d[i].data = res_data[i*DW +: DW];
      end
      pend_d = pend_d + 3'(slot_d[i].full);
    end
  end

  always_comb begin
    wb_we_d   = wb_we_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_fu_d   = wb_fu_q;
    rel_d     = '0;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_any) begin
      wb_rd_d   = slot_q[gnt_idx].rd;
      wb_data_d = slot_q[gnt_idx].data;
      wb_we_d   = (slot_q[gnt_idx].rd != '0);
      wb_fu_d   = gnt;
      rel_d     = gnt;
      rr_ptr_d  = (gnt_idx == PW'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (!wb_stall) begin
      wb_we_d = 1'b0;
      wb_fu_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FU; i++) slot_q[i] <= '0;
      rr_ptr_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_fu_q   <= '0;
      rel_q     <= '0;
      pend_q    <= '0;
    end else begin
      slot_q    <= slot_d;
      rr_ptr_q  <= rr_ptr_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_fu_q   <= wb_fu_d;
      rel_q     <= rel_d;
      pend_q    <= pend_d;
    end
  end

  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_fu      = wb_fu_q;
  assign fu_release = rel_q;
  assign pend_cnt   = pend_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits directly downstream of the functional units (ALU, MEM, MUL, DIV, JUMP), between FU results and the register-file write port.
- Buffers one completed result per FU and grants one register write per cycle using round-robin priority.
- Pulses a per-FU release back to the scoreboard control unit when that FU's result has been written.
- Replaces the direct combinational datatoreg mux once FUs become multi-cycle.

Parameters:
- NUM_FU, 5, number of functional-unit result ports; index 0=ALU, 1=MEM, 2=MUL, 3=DIV, 4=JUMP.
- DW, 32, result data width.
- AW, 5, register address width.

Ports:
- clk  in  1  core clock (debug_clk at top level).
- rst_n  in  1  synchronous reset, active-low.
- res_valid  in  NUM_FU  FU i result valid.
- res_rd  in  NUM_FU*AW  destination register of FU i, slice [i*AW +: AW].
- res_data  in  NUM_FU*DW  result of FU i, slice [i*DW +: DW].
- res_ready  out  NUM_FU  slot i can accept this cycle.
- wb_stall  in  1  freeze the write port: no grant, outputs hold.
- wb_we  out  1  register-file write enable.
- wb_rd  out  AW  write address.
- wb_data  out  DW  write data.
- wb_fu  out  NUM_FU  one-hot source of the current write; zero when idle.
- fu_release  out  NUM_FU  one-cycle pulse, FU i result retired.
- pend_cnt  out  3  number of full slots (debug).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All slots empty; rr_ptr=0.
  - wb_we=0, wb_rd=0, wb_data=0, wb_fu=0, fu_release=0, pend_cnt=0.
  - res_ready reads all-ones the cycle after reset.
  - Reset in mid-operation discards every buffered result without any release pulse.
- Slot i holds {full, rd, data}.
- Acceptance:
  - res_ready[i] = !full[i] | (grant[i] & !wb_stall). This is combinational and gives same-cycle drain and refill.
  - A transfer occurs on res_valid[i] & res_ready[i]. The slot loads on that edge and is full the next cycle.
- Grant (combinational, cycle c):
  - Among the full slots, pick the first index found searching from rr_ptr upward, wrapping modulo NUM_FU.
  - If no slot is full, or wb_stall=1, there is no grant.
- Registered outputs (edge ending cycle c):
  - If slot g is granted: wb_rd=rd[g], wb_data=data[g], wb_fu=1<<g, wb_we=(rd[g]!=0), fu_release=1<<g.
  - Slot g clears unless refilled at the same edge; rr_ptr=(g+1) mod NUM_FU.
  - If there is no grant and wb_stall=0: wb_we=0, wb_fu=0, fu_release=0; wb_rd and wb_data keep their previous values.
  - If wb_stall=1: wb_we, wb_rd, wb_data, wb_fu hold; fu_release=0; rr_ptr holds.
- Latency:
  - A result presented in cycle c with a free slot and no contention gives wb_we=1 in cycle c+2.
  - The register-file write happens at the edge ending cycle c+2.
- rd=0 results (for example stores and branches routed through here) are granted and released normally, with wb_we=0.
- Throughput:
  - One retirement per cycle.
  - With N slots continuously full, each is served within N cycles, so there is no starvation.
- pend_cnt is the registered popcount of full slots after that edge's load and clear.
- Simultaneous load and drain of the same slot at one edge: the new data wins and full stays 1.
- res_valid while res_ready=0 is ignored; the FU must hold its result.

Decomposition:
- Shared package wb_pkg holds:
  - FU index constants FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3, FU_JUMP=4.
  - NUM_FU, DW, AW defaults.
  - The slot record type {full, rd, data}.
- Sub-module rr_pick (NUM_FU-wide round-robin priority picker): inputs req and ptr; outputs one-hot grant and its index.

Test Plan:
- Reset with results pending: load slots 0 and 2, assert rst_n=0 for one edge -> all outputs 0, pend_cnt=0, no fu_release, res_ready=5'b11111.
- Single result: ALU res_rd=5, data=0x12345678 in cycle 1 -> cycle 3 shows wb_we=1, wb_rd=5, wb_data=0x12345678, wb_fu=00001, fu_release=00001; cycle 4 shows wb_we=0.
- Contention: MUL (rd=3) and DIV (rd=4) valid in the same cycle, rr_ptr=0 -> MUL written first, DIV next cycle; rr_ptr ends at 4.
- Round-robin fairness: all five slots held full continuously -> wb_fu sequence 1,2,4,8,16,1,... with no index repeated within 5 cycles.
- rd=0: JUMP result with rd=0, data=0x40 -> wb_we=0, fu_release=10000, slot cleared.
- Stall and refill:
  - ALU slot full, wb_stall=1 for 3 cycles -> outputs hold, res_ready[0]=0, fu_release=0.
  - Stall released with a new ALU result presented the same cycle -> old result written, new result loaded; pend_cnt stays 1.
